// File: rtl/pixel_bus_master_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pixel_bus_master_pkg
// Brief    : Shared types, register map and screen limits for the pixel bus master.
// Revision : 1.0 - initial release
// ============================================================================
package pixel_bus_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SETUP  = 3'd2,
        ST_STROBE = 3'd3,
        ST_HOLD   = 3'd4,
        ST_GAP    = 3'd5
    } busState_t;

    localparam logic [2:0] REG_X_LO  = 3'd0;
    localparam logic [2:0] REG_X_HI  = 3'd1;
    localparam logic [2:0] REG_Y     = 3'd2;
    localparam logic [2:0] REG_COLOR = 3'd3;

    localparam int SCREEN_WIDTH  = 320;
    localparam int SCREEN_HEIGHT = 240;
    localparam int CMD_WIDTH     = 25;

    typedef struct packed {
        logic [8:0] x;
        logic [7:0] y;
        logic [7:0] color;
    } pixelCmd_t;

    // Lowest pending register goes first; colour is always last and commits the pixel.
    function automatic logic [2:0] firstReg(input logic [3:0] mask);
        if (mask[0])      return REG_X_LO;
        else if (mask[1]) return REG_X_HI;
        else if (mask[2]) return REG_Y;
        else              return REG_COLOR;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_bus_master_fifo.sv
`default_nettype none
// ============================================================================
// Module   : pixel_cmd_fifo
// Brief    : Synchronous-write command FIFO with a registered occupancy count.
// Revision : 1.0 - initial release
// ============================================================================
module pixel_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 25
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             pushValid,
    output logic             pushReady,
    input  logic [WIDTH-1:0] pushData,
    input  logic             popEn,
    output logic [WIDTH-1:0] popData,
    output logic             empty
);

    localparam int c_ptrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cntW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [c_ptrW-1:0] r_wrPtr;
    logic [c_ptrW-1:0] r_rdPtr;
    logic [c_cntW-1:0] r_count;
    logic              w_push;
    logic              w_pop;

    // A full FIFO refuses the push even when a pop happens in the same cycle.
    assign pushReady = (r_count != c_cntW'(DEPTH));
    assign empty     = (r_count == '0);
    assign w_push    = pushValid && pushReady;
    assign w_pop     = popEn && !empty;
    assign popData   = r_mem[r_rdPtr];

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= pushData;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wrPtr <= r_wrPtr + c_ptrW'(1);
            if (w_pop)  r_rdPtr <= r_rdPtr + c_ptrW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cntW'(1);
                2'b01:   r_count <= r_count - c_cntW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/pixel_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : pixel_bus_master
// Brief    : Queues pixel commands and replays them as cached MPU register writes.
// Revision : 1.0 - initial release
// ============================================================================
module pixel_bus_master
    import pixel_bus_master_pkg::*;
#(
    parameter int STROBE_CYCLES = 2,
    parameter int GAP_CYCLES    = 1,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cmdValid,
    output logic       cmdReady,
    input  logic [8:0] cmdX,
    input  logic [7:0] cmdY,
    input  logic [7:0] cmdColor,
    output logic       busy,
    output logic       mpuChipSelect,
    output logic       mpuWriteEnable,
    output logic [2:0] mpuRegisterSelect,
    inout  wire  [7:0] mpuData
);

    localparam logic [3:0] c_strobeLast = 4'(STROBE_CYCLES - 1);
    localparam logic [3:0] c_gapLast    = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    busState_t  r_state;
    busState_t  w_nextState;
    pixelCmd_t  w_head;
    pixelCmd_t  r_cmd;
    logic       w_fifoEmpty;
    logic       w_pushFire;
    logic       w_pop;
    logic       w_drive;
    logic [3:0] r_cnt;
    logic [3:0] r_pending;
    logic [3:0] w_loadMask;
    logic [3:0] w_remaining;
    logic [2:0] r_curReg;
    logic [7:0] w_busData;
    logic [8:0] r_cacheX;
    logic [7:0] r_cacheY;
    logic       r_xLoValid;
    logic       r_xHiValid;
    logic       r_yValid;

    pixel_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_WIDTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .pushValid (cmdValid),
        .pushReady (cmdReady),
        .pushData  ({cmdX, cmdY, cmdColor}),
        .popEn     (w_pop),
        .popData   (w_head),
        .empty     (w_fifoEmpty)
    );

    assign w_pushFire = cmdValid && cmdReady;
    assign busy       = (r_state != ST_IDLE) || !w_fifoEmpty || w_pushFire;

    // Invalid cache fields force a write, so the first command after reset writes all four.
    assign w_loadMask = {1'b1,
                         !r_yValid   || (w_head.y      != r_cacheY),
                         !r_xHiValid || (w_head.x[8]   != r_cacheX[8]),
                         !r_xLoValid || (w_head.x[7:0] != r_cacheX[7:0])};
    assign w_remaining = r_pending & ~(4'b0001 << r_curReg);

    always_comb begin
        w_nextState = r_state;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE:   if (!w_fifoEmpty || w_pushFire) w_nextState = ST_LOAD;
            ST_LOAD: begin
                w_pop       = 1'b1;
                w_nextState = ST_SETUP;
            end
            ST_SETUP:  w_nextState = ST_STROBE;
            ST_STROBE: if (r_cnt == c_strobeLast) w_nextState = ST_HOLD;
            ST_HOLD: begin
                if (w_remaining != 4'd0)  w_nextState = ST_SETUP;
                else if (GAP_CYCLES != 0) w_nextState = ST_GAP;
                else                      w_nextState = w_fifoEmpty ? ST_IDLE : ST_LOAD;
            end
            ST_GAP:    if (r_cnt == c_gapLast) w_nextState = w_fifoEmpty ? ST_IDLE : ST_LOAD;
            default:   w_nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cmd      <= '0;
            r_cnt      <= '0;
            r_pending  <= '0;
            r_curReg   <= REG_X_LO;
            r_cacheX   <= '0;
            r_cacheY   <= '0;
            r_xLoValid <= 1'b0;
            r_xHiValid <= 1'b0;
            r_yValid   <= 1'b0;
        end else begin
            r_state <= w_nextState;
            case (r_state)
                ST_LOAD: begin
                    r_cmd     <= w_head;
                    r_pending <= w_loadMask;
                    r_curReg  <= firstReg(w_loadMask);
                end
                ST_SETUP:  r_cnt <= '0;
                ST_STROBE: r_cnt <= r_cnt + 4'd1;
                ST_HOLD: begin
                    r_cnt     <= '0;
                    r_pending <= w_remaining;
                    if (w_remaining != 4'd0) r_curReg <= firstReg(w_remaining);
                    case (r_curReg)
                        REG_X_LO: begin
                            r_cacheX[7:0] <= r_cmd.x[7:0];
                            r_xLoValid    <= 1'b1;
                        end
                        REG_X_HI: begin
                            r_cacheX[8] <= r_cmd.x[8];
                            r_xHiValid  <= 1'b1;
                        end
                        REG_Y: begin
                            r_cacheY <= r_cmd.y;
                            r_yValid <= 1'b1;
                        end
                        default: r_cnt <= '0;
                    endcase
                end
                ST_GAP:    r_cnt <= r_cnt + 4'd1;
                default:   r_cnt <= r_cnt;
            endcase
        end
    end

    always_comb begin
        w_busData = r_cmd.color;
        case (r_curReg)
            REG_X_LO: w_busData = r_cmd.x[7:0];
            REG_X_HI: w_busData = {7'b0, r_cmd.x[8]};
            REG_Y:    w_busData = r_cmd.y;
            default:  w_busData = r_cmd.color;
        endcase
    end

    // Strobes decode straight from the state register so reset drops them asynchronously.
    assign w_drive           = (r_state == ST_SETUP) || (r_state == ST_STROBE) || (r_state == ST_HOLD);
    assign mpuChipSelect     = (r_state == ST_STROBE);
    assign mpuWriteEnable    = (r_state == ST_STROBE);
    assign mpuRegisterSelect = r_curReg;
    assign mpuData           = w_drive ? w_busData : 8'bz;

endmodule
`default_nettype wire

// File: doc/pixel_bus_master.md
PIXEL_BUS_MASTER -- requirements
Module: pixel_bus_master

Interface
REQ-001 Parameter STROBE_CYCLES, default 2, number of cycles chip select and write enable stay asserted per register write (legal range 1-15).
REQ-002 Parameter GAP_CYCLES, default 1, number of idle cycles after each completed pixel command (legal range 0-15).
REQ-003 Parameter FIFO_DEPTH, default 4, depth of the pixel command FIFO (power of two, 2-16).
REQ-004 clock  input  1  single system clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 cmdValid  input  1  pixel command offered.
REQ-007 cmdReady  output  1  FIFO can accept a command.
REQ-008 cmdX  input  9  pixel X coordinate, 0-319.
REQ-009 cmdY  input  8  pixel Y coordinate, 0-239.
REQ-010 cmdColor  input  8  pixel colour byte.
REQ-011 busy  output  1  FIFO non-empty or bus cycle in progress.
REQ-012 mpuChipSelect  output  1  active-high chip select to the video device.
REQ-013 mpuWriteEnable  output  1  active-high write strobe.
REQ-014 mpuRegisterSelect  output  3  target register.
REQ-015 mpuData  inout  8  data bus, driven only in SETUP, STROBE and HOLD, high-Z otherwise.

Function
REQ-016 Register map: 0 = X[7:0], 1 = {7'b0, X[8]}, 2 = Y, 3 = colour; a write to register 3 commits the pixel.
REQ-017 Command accepted on a cycle with cmdValid and cmdReady both high; cmdReady = not full.
REQ-018 Simultaneous push and pop on a full FIFO: push refused (cmdReady low), pop proceeds, count decreases by one.
REQ-019 Simultaneous push and pop on a non-full FIFO: count unchanged, ordering preserved.
REQ-020 Each command expands to an ordered write list: reg 0 if X[7:0] differs from cache, reg 1 if X[8] differs, reg 2 if Y differs, reg 3 always.
REQ-021 Cache holds last written X and Y; cache is invalid after reset, so the first command writes all four registers.
REQ-022 Cache entries update at the end of the HOLD cycle of their register write.
REQ-023 FSM states IDLE, LOAD, SETUP, STROBE, HOLD, GAP.
REQ-024 IDLE -> LOAD when FIFO non-empty; LOAD pops one entry and computes the write list (1 cycle).
REQ-025 SETUP: 1 cycle, register select and data driven, chip select and write enable low.
REQ-026 STROBE: exactly STROBE_CYCLES cycles, chip select and write enable high, select and data stable.
REQ-027 HOLD: 1 cycle, strobes low, select and data held; then SETUP of next pending write, else GAP.
REQ-028 GAP: GAP_CYCLES cycles, bus high-Z; then LOAD if FIFO non-empty else IDLE; GAP_CYCLES = 0 skips GAP.
REQ-029 Latency: command accepted into empty FIFO in IDLE produces first chip-select-high cycle 3 cycles later (accept, LOAD, SETUP).
REQ-030 Full command with all four writes: 1 + 4*(STROBE_CYCLES+2) + GAP_CYCLES cycles from LOAD to next LOAD (= 18 at defaults).
REQ-031 Repeat command with same X and Y: register 3 write only.
REQ-032 busy high from the accept cycle until the last GAP cycle completes with FIFO empty.

Reset
REQ-033 Reset asserted at any time: FSM to IDLE, FIFO empty, cache invalid, chip select and write enable 0, register select 0, data bus high-Z, cmdReady 1, busy 0.
REQ-034 Reset mid-STROBE deasserts strobes asynchronously; the interrupted command is discarded, not replayed.

Structure
REQ-035 Shared package holds the FSM state enum, register-index constants (REG_X_LO, REG_X_HI, REG_Y, REG_COLOR) and screen limits 320/240.
REQ-036 One sub-module: pixel_cmd_fifo (synchronous-write, registered-count FIFO, 25-bit entries).

Verification
REQ-037 Reset, push (X=5, Y=7, colour=0xA5) -> writes reg0=0x05, reg1=0x00, reg2=0x07, reg3=0xA5, each strobe 2 cycles.
REQ-038 Push (5,7,0x11) after previous -> only reg3=0x11 written; LOAD-to-idle time 1+4+1 cycles.
REQ-039 Push (300,7,0x22) after (5,7) -> reg0=0x2C, reg1=0x01, reg3=0x22; no reg2 write.
REQ-040 Push 5 commands back-to-back with FIFO_DEPTH=4 -> cmdReady low once 4 entries held; all 5 committed in order.
REQ-041 Assert reset during STROBE of reg2 -> strobes 0 same cycle, mpuData high-Z; next command writes all four registers.
REQ-042 Check mpuData high-Z in IDLE and GAP; select and data stable through SETUP-STROBE-HOLD.
